// File: rtl/exc_redirect_ctrl.sv
// Exception/ERET flush and fetch-redirect sequencer for the WB -> pre-IF path.
// Latches the redirect target and discards inst-SRAM responses of flushed fetches.
module exc_redirect_ctrl #(
    parameter logic [31:0] EX_ENTRY  = 32'hbfc00380,
    parameter int unsigned MAX_OUTST = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_ex,
    input  logic        eret_flush,
    input  logic [31:0] cp0_epc,
    input  logic        inst_req_fire,
    input  logic        inst_resp,
    input  logic        redirect_ready,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        resp_discard,
    output logic        fetch_allow,
    output logic        busy
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t             state;
    logic               trig;
    logic [CNT_W-1:0]   outst;
    logic [CNT_W-1:0]   outst_nxt;
    logic [CNT_W-1:0]   disc;

    assign trig         = ws_ex | eret_flush;
    assign pipe_flush   = (state == IDLE) && trig;
    assign fetch_allow  = (outst < CNT_W'(MAX_OUTST));
    assign resp_discard = inst_resp && (disc != '0);
    assign busy         = (state == REDIRECT) || (disc != '0);

    // A request and a response in the same cycle cancel; a stray response saturates at zero.
    always_comb begin
        outst_nxt = outst;
        if (inst_req_fire && !inst_resp)
            outst_nxt = outst + CNT_W'(1);
        else if (!inst_req_fire && inst_resp && (outst != '0))
            outst_nxt = outst - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state          <= REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= ws_ex ? EX_ENTRY : cp0_epc;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    // Everything still in flight after the flush cycle (including a request fired
    // in that cycle) belongs to the old stream; a reload covers back-to-back traps.
    always_ff @(posedge clk) begin
        if (reset) begin
            outst <= '0;
            disc  <= '0;
        end else begin
            outst <= outst_nxt;
            if (pipe_flush)
                disc <= outst_nxt;
            else if (resp_discard)
                disc <= disc - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(inst_req_fire && !fetch_allow));
            assert (!(inst_resp && (outst == '0)));
        end
    end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Scoreboard bench for exc_redirect_ctrl: per-cycle expectations from a queue-based
// model of in-flight fetches are pushed by the driver and checked by a monitor.
module tb_exc_redirect_ctrl;

    localparam logic [31:0] EXV = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        reset, ws_ex, eret_flush, inst_req_fire, inst_resp, redirect_ready;
    logic [31:0] cp0_epc;
    logic        pipe_flush, redirect_valid, resp_discard, fetch_allow, busy;
    logic [31:0] redirect_pc;

    exc_redirect_ctrl #(.EX_ENTRY(EXV), .MAX_OUTST(3)) dut (
        .clk(clk), .reset(reset), .ws_ex(ws_ex), .eret_flush(eret_flush),
        .cp0_epc(cp0_epc), .inst_req_fire(inst_req_fire), .inst_resp(inst_resp),
        .redirect_ready(redirect_ready), .pipe_flush(pipe_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .resp_discard(resp_discard), .fetch_allow(fetch_allow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        bit          pf;
        bit          rv;
        logic [31:0] pc;
        bit          rd;
        bit          fa;
        bit          bz;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: each in-flight fetch is a queue entry flagged stale once flushed.
    bit          stale_q[$];
    bit          pend   = 1'b0;
    logic [31:0] mpc    = '0;
    bit          m_idle = 1'b1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(bit ex, bit er, logic [31:0] epc, bit fire, bit resp, bit rdy,
                       bit rst, bit en = 1'b1);
        exp_t e;
        bit   trig_eff, front_stale, disc_any;
        @(posedge clk);
        #1;
        reset = rst; ws_ex = ex; eret_flush = er; cp0_epc = epc;
        inst_req_fire = fire; inst_resp = resp; redirect_ready = rdy;
        disc_any    = 1'b0;
        foreach (stale_q[i]) if (stale_q[i]) disc_any = 1'b1;
        front_stale = (stale_q.size() != 0) && stale_q[0];
        trig_eff    = m_idle && (ex || er);
        e.en = en;
        e.pf = trig_eff;
        e.rv = pend;
        e.pc = mpc;
        e.rd = resp && front_stale;
        e.fa = (stale_q.size() < 3);
        e.bz = pend || disc_any;
        sb.push_back(e);
        if (rst) begin
            stale_q.delete();
            pend = 1'b0; mpc = '0; m_idle = 1'b1;
        end else begin
            if (resp && stale_q.size() != 0) void'(stale_q.pop_front());
            if (fire) stale_q.push_back(1'b0);
            if (trig_eff) begin
                foreach (stale_q[i]) stale_q[i] = 1'b1;
                pend = 1'b1; m_idle = 1'b0;
                mpc  = ex ? EXV : epc;
            end else if (pend && rdy) begin
                pend = 1'b0; m_idle = 1'b1;
            end
        end
    endtask

    task automatic idle(int n, bit rdy = 1'b0);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 0, rdy, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.en) begin
                    chk("pipe_flush", {31'b0, pipe_flush}, {31'b0, e.pf});
                    chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, e.rv});
                    chk("redirect_pc", redirect_pc, e.pc);
                    chk("resp_discard", {31'b0, resp_discard}, {31'b0, e.rd});
                    chk("fetch_allow", {31'b0, fetch_allow}, {31'b0, e.fa});
                    chk("busy", {31'b0, busy}, {31'b0, e.bz});
                end
            end
        end
    end

    initial begin : driver
        bit f, r, x, er, rdy, rst;
        reset = 1'b1; ws_ex = 0; eret_flush = 0; cp0_epc = '0;
        inst_req_fire = 0; inst_resp = 0; redirect_ready = 0;
        cyc(0, 0, 32'h0, 0, 0, 0, 1, 0);
        cyc(0, 0, 32'h0, 0, 0, 0, 1);
        idle(2);

        // exception with nothing in flight, immediate accept
        cyc(1, 0, 32'h0, 0, 0, 1, 0);
        idle(3, 1);
        // ERET with redirect held off for three cycles
        cyc(0, 1, 32'h80001234, 0, 0, 0, 0);
        idle(3, 0);
        idle(2, 1);
        // simultaneous exception and ERET: vector wins
        cyc(1, 1, 32'h12345678, 0, 0, 0, 0);
        idle(2, 1);
        // two in flight plus a fire in the flush cycle
        cyc(0, 0, 32'h0, 1, 0, 0, 0);
        cyc(0, 0, 32'h0, 1, 0, 0, 0);
        cyc(1, 0, 32'h0, 1, 0, 0, 0);
        cyc(0, 0, 32'h0, 0, 0, 1, 0);
        cyc(0, 0, 32'h0, 0, 1, 0, 0);
        cyc(0, 0, 32'h0, 1, 1, 0, 0);
        cyc(0, 0, 32'h0, 0, 1, 0, 0);
        cyc(0, 0, 32'h0, 0, 1, 0, 0);
        idle(2);
        // fill to MAX_OUTST, then free one slot
        for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 1, 0, 0, 0);
        idle(1);
        cyc(0, 0, 32'h0, 0, 1, 0, 0);
        idle(1);
        cyc(0, 0, 32'h0, 0, 1, 0, 0);
        cyc(0, 0, 32'h0, 0, 1, 0, 0);
        // reset during a redirect with two discards pending
        cyc(0, 0, 32'h0, 1, 0, 0, 0);
        cyc(0, 0, 32'h0, 1, 0, 0, 0);
        cyc(1, 0, 32'h0, 0, 0, 0, 0);
        cyc(0, 0, 32'h0, 0, 0, 0, 1);
        idle(1);
        cyc(0, 0, 32'h0, 1, 0, 0, 0);
        cyc(0, 0, 32'h0, 0, 1, 0, 0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            f   = (stale_q.size() < 3) && ($urandom_range(0, 1) == 1);
            r   = (stale_q.size() != 0) && ($urandom_range(0, 1) == 1);
            x   = ($urandom_range(0, 11) == 0);
            er  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 149) == 0);
            if (rst) begin f = 0; r = 0; x = 0; er = 0; end
            cyc(x, er, $urandom, f, r, rdy, rst);
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
